// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI response/burst encodings, the fill
// FSM state type and helpers for the line-fill derived widths.
package cc_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } fill_state_e;

  function automatic int beats_f(input int line_bytes, input int data_w);
    return (line_bytes * 8) / data_w;
  endfunction

  // A single-beat line still needs a 1-bit pointer/counter to exist.
  function automatic int ptr_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int tag_w_f(input int addr_w, input int index_w, input int line_bytes);
    return addr_w - index_w - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/cc_line_fill_unit_if.sv
// Miss-address FIFO pop channel and memory read-data channel of the line-fill unit.
interface cc_line_fill_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic              miss_valid_i;
  logic [ADDR_W-1:0] miss_addr_i;
  logic              miss_ready_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [1:0]        mem_rresp_i;
  logic              mem_rlast_i;
  logic              mem_rvalid_i;
  logic              mem_rready_o;

  modport slave (
    input  miss_valid_i, miss_addr_i, mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i,
    output miss_ready_o, mem_rready_o
  );

  modport master (
    output miss_valid_i, miss_addr_i, mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i,
    input  miss_ready_o, mem_rready_o
  );

endinterface

// File: rtl/cc_line_fill_unit.sv
// Cache-line fill engine: accepts one miss, gathers the read burst into a line
// buffer and writes {valid, tag} plus the whole line to the tag/data SRAM at once.
module cc_line_fill_unit
  import cc_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int INDEX_W    = 9,
  parameter bit WRAP_EN    = 1'b1,
  localparam int TAG_W     = tag_w_f(ADDR_W, INDEX_W, LINE_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cc_line_fill_unit_if.slave      bus,
  output logic                    wren_o,
  output logic [INDEX_W-1:0]      waddr_o,
  output logic [TAG_W:0]          wdata_tag_o,
  output logic [LINE_BYTES*8-1:0] wdata_data_o,
  output logic                    fill_done_o,
  output logic                    fill_err_o,
  output logic                    busy_o
);

  localparam int BEATS    = beats_f(LINE_BYTES, DATA_W);
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int BOFF_W   = $clog2(DATA_W / 8);
  localparam int PTR_W    = ptr_w_f(BEATS);
  localparam logic [PTR_W-1:0] LAST_CNT = PTR_W'(BEATS - 1);

  fill_state_e        state_q;
  logic [PTR_W-1:0]   ptr_q, cnt_q, crit_beat;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q, waddr_q;
  logic [TAG_W:0]     wtag_q;
  logic               err_q, miss_ready_q, rready_q, busy_q, wren_q, done_q, ferr_q;
  logic [DATA_W-1:0]  line_q [BEATS];
  logic [LINE_BYTES*8-1:0] line_flat;
  logic               beat, resp_bad, end_burst, err_d;
  logic [OFFSET_W-1:0] unused_offset;

  assign unused_offset = bus.miss_addr_i[OFFSET_W-1:0];

  generate
    if (BEATS > 1) begin : g_crit
      assign crit_beat = WRAP_EN ? bus.miss_addr_i[OFFSET_W-1:BOFF_W] : '0;
    end else begin : g_crit_single
      assign crit_beat = '0;
    end
  endgenerate

  // A burst ends on rlast or on the BEATS-th beat; any disagreement between the two is a length error.
  always_comb begin
    beat      = rready_q && bus.mem_rvalid_i;
    resp_bad  = (bus.mem_rresp_i == RESP_SLVERR) || (bus.mem_rresp_i == RESP_DECERR);
    end_burst = bus.mem_rlast_i || (cnt_q == LAST_CNT);
    err_d     = err_q || resp_bad || (bus.mem_rlast_i != (cnt_q == LAST_CNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      tag_q        <= '0;
      index_q      <= '0;
      err_q        <= 1'b0;
      miss_ready_q <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      wren_q       <= 1'b0;
      done_q       <= 1'b0;
      ferr_q       <= 1'b0;
      waddr_q      <= '0;
      wtag_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          miss_ready_q <= 1'b1;
          if (bus.miss_valid_i && miss_ready_q) begin
            tag_q        <= bus.miss_addr_i[ADDR_W-1 -: TAG_W];
            index_q      <= bus.miss_addr_i[OFFSET_W +: INDEX_W];
            ptr_q        <= crit_beat;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            miss_ready_q <= 1'b0;
            rready_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= FILL;
          end
        end
        FILL: begin
          if (beat) begin
            ptr_q <= ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + PTR_W'(1);
            err_q <= err_d;
            if (end_burst) begin
              rready_q <= 1'b0;
              done_q   <= 1'b1;
              ferr_q   <= err_d;
              wren_q   <= !err_d;
              waddr_q  <= index_q;
              wtag_q   <= {1'b1, tag_q};
              state_q  <= WRITE;
            end
          end
        end
        WRITE: begin
          done_q       <= 1'b0;
          ferr_q       <= 1'b0;
          wren_q       <= 1'b0;
          busy_q       <= 1'b0;
          miss_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line buffer holds data only; its contents are meaningless until a fill completes.
  always_ff @(posedge clk) begin
    if (beat) line_q[ptr_q] <= bus.mem_rdata_i;
  end

  always_comb begin
    line_flat = '0;
    for (int k = 0; k < BEATS; k++) line_flat[k*DATA_W +: DATA_W] = line_q[k];
  end

  assign bus.miss_ready_o = miss_ready_q;
  assign bus.mem_rready_o = rready_q;
  assign wren_o           = wren_q;
  assign waddr_o          = waddr_q;
  assign wdata_tag_o      = wtag_q;
  assign wdata_data_o     = wren_q ? line_flat : '0;
  assign fill_done_o      = done_q;
  assign fill_err_o       = ferr_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_cc_line_fill_unit.sv
// Drives an incrementing-burst and a wrap-burst fill unit with the same traffic
// and checks both against a line-placement reference model.
module tb_cc_line_fill_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        miss_valid;
  logic [31:0] miss_addr;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;

  cc_line_fill_unit_if #(.ADDR_W(32), .DATA_W(64)) if_i ();
  cc_line_fill_unit_if #(.ADDR_W(32), .DATA_W(64)) if_w ();

  assign if_i.miss_valid_i = miss_valid;
  assign if_i.miss_addr_i  = miss_addr;
  assign if_i.mem_rdata_i  = rdata;
  assign if_i.mem_rresp_i  = rresp;
  assign if_i.mem_rlast_i  = rlast;
  assign if_i.mem_rvalid_i = rvalid;
  assign if_w.miss_valid_i = miss_valid;
  assign if_w.miss_addr_i  = miss_addr;
  assign if_w.mem_rdata_i  = rdata;
  assign if_w.mem_rresp_i  = rresp;
  assign if_w.mem_rlast_i  = rlast;
  assign if_w.mem_rvalid_i = rvalid;

  logic         wren_i, done_i, ferr_i, busy_i, wren_w, done_w, ferr_w, busy_w;
  logic [8:0]   waddr_i, waddr_w;
  logic [17:0]  tag_i, tag_w;
  logic [511:0] data_i, data_w;

  cc_line_fill_unit #(.WRAP_EN(1'b0)) dut_i (
    .clk(clk), .rst_n(rst_n), .bus(if_i.slave),
    .wren_o(wren_i), .waddr_o(waddr_i), .wdata_tag_o(tag_i), .wdata_data_o(data_i),
    .fill_done_o(done_i), .fill_err_o(ferr_i), .busy_o(busy_i)
  );

  cc_line_fill_unit #(.WRAP_EN(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(if_w.slave),
    .wren_o(wren_w), .waddr_o(waddr_w), .wdata_tag_o(tag_w), .wdata_data_o(data_w),
    .fill_done_o(done_w), .fill_err_o(ferr_w), .busy_o(busy_w)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".i.wren"}, wren_i, 0);        chk({tag, ".w.wren"}, wren_w, 0);
    chk({tag, ".i.done"}, done_i, 0);        chk({tag, ".w.done"}, done_w, 0);
    chk({tag, ".i.ferr"}, ferr_i, 0);        chk({tag, ".w.ferr"}, ferr_w, 0);
    chk({tag, ".i.busy"}, busy_i, 0);        chk({tag, ".w.busy"}, busy_w, 0);
    chk({tag, ".i.mready"}, if_i.miss_ready_o, 0);
    chk({tag, ".w.mready"}, if_w.miss_ready_o, 0);
    chk({tag, ".i.rready"}, if_i.mem_rready_o, 0);
    chk({tag, ".w.rready"}, if_w.mem_rready_o, 0);
    chk({tag, ".i.waddr"}, waddr_i, 0);      chk({tag, ".w.waddr"}, waddr_w, 0);
    chk({tag, ".i.tag"}, tag_i, 0);          chk({tag, ".w.tag"}, tag_w, 0);
    chk({tag, ".i.data"}, data_i, 0);        chk({tag, ".w.data"}, data_w, 0);
  endtask

  // nb beats are offered; rlast rides on beat last_at (-1: never); beat bad_at carries an
  // error response (-1: none); abort_at (-1: never) pulls reset before that beat.
  task automatic do_fill(input string tag, input logic [31:0] addr, input int nb,
                         input int last_at, input int bad_at, input bit gaps,
                         input bit seq, input int abort_at);
    logic [63:0]  d;
    logic [511:0] exp_i, exp_w;
    logic [17:0]  exp_tag;
    logic [8:0]   exp_idx;
    int           crit;
    bit           exp_err, ok;
    crit    = (addr / 8) % 8;
    exp_idx = 9'((addr / 64) % 512);
    exp_tag = 18'((1 << 17) + addr / (64 * 512));
    exp_err = (last_at != 7) || (bad_at >= 0);
    exp_i   = '0;
    exp_w   = '0;

    miss_addr  = addr;
    miss_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = if_i.miss_ready_o && if_w.miss_ready_o;
      @(posedge clk); #1;
    end
    miss_valid = 1'b0;
    miss_addr  = $urandom;
    chk({tag, ".miss_accept"}, ok, 1);
    chk({tag, ".i.busy_fill"}, busy_i, 1);
    chk({tag, ".w.rready_fill"}, if_w.mem_rready_o, 1);

    for (int n = 0; n < nb; n++) begin
      if (n == abort_at) begin
        rvalid = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_all_zero({tag, ".abort"});
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (gaps) begin
        rvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      d      = seq ? 64'(n + 1) : {$urandom, $urandom};
      rdata  = d;
      rvalid = 1'b1;
      rresp  = (n == bad_at) ? (2'b10 | 2'($urandom_range(0, 1))) : 2'($urandom_range(0, 1));
      rlast  = (n == last_at);
      if (n < 8) begin
        exp_i[n * 64 +: 64]              = d;
        exp_w[((crit + n) % 8) * 64 +: 64] = d;
      end
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        ok = if_i.mem_rready_o && if_w.mem_rready_o;
        @(posedge clk); #1;
      end
      chk({tag, ".beat_accept"}, ok, 1);
    end
    rlast = 1'b0;
    rresp = 2'b00;

    // Cycle after the final handshake: the SRAM write (or error pulse) is visible now.
    chk({tag, ".i.done"}, done_i, 1);            chk({tag, ".w.done"}, done_w, 1);
    chk({tag, ".i.wren"}, wren_i, !exp_err);     chk({tag, ".w.wren"}, wren_w, !exp_err);
    chk({tag, ".i.ferr"}, ferr_i, exp_err);      chk({tag, ".w.ferr"}, ferr_w, exp_err);
    chk({tag, ".i.rready_write"}, if_i.mem_rready_o, 0);
    chk({tag, ".w.rready_write"}, if_w.mem_rready_o, 0);
    if (!exp_err) begin
      chk({tag, ".i.waddr"}, waddr_i, exp_idx);  chk({tag, ".w.waddr"}, waddr_w, exp_idx);
      chk({tag, ".i.tag"}, tag_i, exp_tag);      chk({tag, ".w.tag"}, tag_w, exp_tag);
      chk({tag, ".i.data"}, data_i, exp_i);      chk({tag, ".w.data"}, data_w, exp_w);
    end
    rvalid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".i.done_clr"}, done_i, 0);        chk({tag, ".w.wren_clr"}, wren_w, 0);
    chk({tag, ".i.ferr_clr"}, ferr_i, 0);        chk({tag, ".w.busy_clr"}, busy_w, 0);
    chk({tag, ".i.mready_next"}, if_i.miss_ready_o, 1);
    chk({tag, ".w.mready_next"}, if_w.miss_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    rdata      = '0;
    rresp      = 2'b00;
    rlast      = 1'b0;
    rvalid     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray read data while idle must be ignored.
    rvalid = 1'b1;
    rdata  = 64'hDEAD_BEEF_0BAD_F00D;
    rlast  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray.i.rready", if_i.mem_rready_o, 0);
      chk("stray.w.rready", if_w.mem_rready_o, 0);
      chk("stray.i.busy", busy_i, 0);
      chk("stray.w.wren", wren_w, 0);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;

    do_fill("incr_8040", 32'h0000_8040, 8, 7, -1, 1'b0, 1'b1, -1);
    do_fill("wrap_0128", 32'h0000_0128, 8, 7, -1, 1'b0, 1'b0, -1);
    do_fill("resp_err",  32'h1234_5678, 8, 7,  3, 1'b0, 1'b0, -1);
    do_fill("short",     32'h0000_0ab8, 6, 5, -1, 1'b0, 1'b0, -1);
    do_fill("no_rlast",  32'h8000_0010, 8, -1, -1, 1'b0, 1'b0, -1);
    for (int r = 0; r < 6; r++)
      do_fill("rand", $urandom, 8, 7, -1, 1'b1, 1'b0, -1);
    do_fill("abort",     32'h0000_0168, 8, 7, -1, 1'b1, 1'b0, 4);
    do_fill("post_rst",  32'h0000_0040, 8, 7, -1, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_line_fill_unit.md
Name: cc_line_fill_unit

Overview:
Parametrised cache-line fill engine for the cache controller. It takes one miss address at a time from the miss-address FIFO, collects the memory read burst for that line into a line buffer, and writes the full line with its tag into the tag/data SRAM in a single write.
- Compared with the fixed 64-bit/64-byte fill path, it adds parametrised data width, line size and index width.
- Adds a wrap-burst (critical-word-first) placement mode.
- Adds checking of response and burst length; on a failed burst it suppresses the SRAM write.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, memory R-channel beat width in bits; power of two, at least 8
LINE_BYTES, 64, cache line size in bytes; power of two, LINE_BYTES*8 >= DATA_W
INDEX_W, 9, SRAM index width
WRAP_EN, 1, 1: burst starts at the critical beat and wraps; 0: incrementing burst that starts at beat 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
miss_valid_i  in  1  miss-address FIFO not empty
miss_addr_i  in  ADDR_W  miss address at the FIFO head
miss_ready_o  out  1  pops the FIFO; the address is taken when valid&ready
mem_rdata_i  in  DATA_W  memory read data
mem_rresp_i  in  2  memory read response
mem_rlast_i  in  1  last beat of the burst
mem_rvalid_i  in  1  read data valid
mem_rready_o  out  1  read data ready
wren_o  out  1  SRAM write enable
waddr_o  out  INDEX_W  SRAM write index
wdata_tag_o  out  TAG_W+1  {valid=1, tag}
wdata_data_o  out  LINE_BYTES*8  line data; beat k occupies bits [k*DATA_W +: DATA_W]
fill_done_o  out  1  one-cycle pulse when a fill completes (good or bad)
fill_err_o  out  1  one-cycle pulse when a fill completes with an error
busy_o  out  1  a fill is in progress (state is not IDLE)

Behaviour:
- Derived widths: BEATS=LINE_BYTES*8/DATA_W; OFFSET_W=log2(LINE_BYTES); BOFF_W=log2(DATA_W/8); TAG_W=ADDR_W-INDEX_W-OFFSET_W.
- Address split: tag=addr[ADDR_W-1 -: TAG_W]; index=addr[OFFSET_W +: INDEX_W]; critical beat=addr[OFFSET_W-1:BOFF_W].
- Reset: all outputs 0, FSM in IDLE, line buffer contents don't-care.
- FSM IDLE:
  - miss_ready_o=1 and mem_rready_o=0.
  - On miss_valid_i: latch tag and index, set ptr to the critical beat if WRAP_EN=1 (else 0), clear cnt and err, go to FILL.
- FSM FILL:
  - mem_rready_o=1 and miss_ready_o=0.
  - Each beat (rvalid&rready) writes buf[ptr]. ptr increments mod BEATS; the wrap is natural in log2(BEATS) bits.
  - err is made sticky-1 if mem_rresp_i[1]=1 (SLVERR/DECERR).
  - Beat with rlast: set err if cnt!=BEATS-1; go to WRITE.
  - Beat with cnt==BEATS-1 and no rlast: set err, drop mem_rready_o, go to WRITE. Extra beats are not consumed; recovering from them is upstream's job.
  - cnt increments on each beat.
- FSM WRITE (exactly one cycle):
  - fill_done_o=1.
  - If err=0: wren_o=1, waddr_o=index, wdata_tag_o={1'b1,tag}, wdata_data_o=buf.
  - If err=1: wren_o=0 and fill_err_o=1; the SRAM is untouched.
  - Go to IDLE. A new miss can be accepted the following cycle.
- Latency: SRAM write occurs the cycle after the last beat handshake. Miss accept to first-beat readiness is 1 cycle.
- mem_rvalid_i while in IDLE or WRITE is not accepted (rready=0); no state change.
- BEATS==1 is legal: FILL takes one beat, which must carry rlast.
- Reset mid-fill: the partial line is discarded, no wren_o, FSM returns to IDLE. The miss that was in flight is lost.
- wren_o, waddr_o, wdata_* and the pulse outputs are registered. wdata_data_o is driven from buf and is only meaningful while wren_o=1.

Decomposition:
- Shared package cc_pkg holds:
  - AXI RESP constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
  - Burst encodings (INCR=2'b01, WRAP=2'b10).
  - Fill FSM state enum (IDLE, FILL, WRITE).
  - Width helper functions for the derived widths.
- Single module; the line buffer is an inline register array and no sub-module is needed.

Test Plan:
- INCR, WRAP_EN=0 (default widths otherwise): addr 0x0000_8040 with beats 64'h1..64'h8 and rlast on the 8th -> one wren, waddr=9'h001, wdata_tag=18'h20001, slot k = k+1, fill_done pulse, no err.
- Wrap, WRAP_EN=1: addr 0x0000_0128 (critical beat 5, index 4, tag 0) with beats D0..D7 -> D0..D2 land in slots 5,6,7 and D3..D7 in slots 0..4; waddr=4, tag=18'h20000.
- Error response: rresp=2'b10 on beat 3, rest OKAY -> wren stays 0, fill_err and fill_done pulse together; the next miss is accepted the cycle after WRITE.
- Length error: rlast on beat 6 -> err, no wren. Separately, 8 beats with no rlast -> mem_rready_o drops after beat 8, err pulse, no wren.
- Stalls and stray data: rvalid asserted in IDLE -> no capture, rready=0; in FILL, toggle rvalid randomly with gaps -> the line is still assembled correctly.
- Reset mid-fill: rst_n low after 4 beats -> all outputs 0 at once and no wren; after reset, a fresh fill of 0x0000_0040 completes normally with waddr=1.
